// File: rtl/register_file_wb.sv
// register_file_wb: 32 x XLEN integer register file at the end of the writeback
// path. It has two combinational decode read ports with same-cycle writeback
// bypass, a handshaked debug access port that is usable only while the pipeline
// is frozen, and a counter of retired pipeline writes.
module register_file_wb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            dbg,
  input  logic            mem_hold,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            dbg_ack,
  output logic [31:0]     wb_count
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE,
    RELEASE
  } dbg_state_t;

  logic [XLEN-1:0] regs [NREGS];
  logic            commit;
  logic            dbg_access;
  dbg_state_t      state;
  dbg_state_t      state_next;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [31:0]     cnt_q;

  // A pipeline write retires only outside debug, outside a memory stall and
  // never to x0. A reset on the same edge takes priority over the write.
  assign commit = !Rst && wb_we && !dbg && !mem_hold && (wb_rd != '0);

  // The debug access happens on the edge that leaves XFER. If dbg has already
  // dropped, that edge is an abort instead and nothing is touched.
  assign dbg_access = (state == XFER) && dbg;

  assign wb_count = cnt_q;

  // Read port 1: x0 reads as zero, otherwise a same-cycle commit is bypassed
  always_comb begin
    // NOTE: assigning a default first means every path drives the output, so
    // no latch is inferred when a branch below is skipped.
    rs1_data = '0;
    if (rs1 != '0) begin
      if (commit && (wb_rd == rs1)) rs1_data = wb_data;
      else                          rs1_data = regs[rs1];
    end
  end

  // Read port 2: same rules as port 1, independent of it
  always_comb begin
    rs2_data = '0;
    if (rs2 != '0) begin
      if (commit && (wb_rd == rs2)) rs2_data = wb_data;
      else                          rs2_data = regs[rs2];
    end
  end

  // Debug handshake next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (dbg && dbg_req) state_next = XFER;
      XFER:    state_next = dbg ? DONE : IDLE;
      DONE:    state_next = dbg ? RELEASE : IDLE;
      // Stay here until the requester lets go, so that a request held high
      // cannot start a second access.
      RELEASE: if (!dbg_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Debug state register and capture of the request fields
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before this edge whatever order the statements are in.
    if (Rst) begin
      state     <= IDLE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && dbg && dbg_req) begin
        req_we    <= dbg_we;
        req_addr  <= dbg_addr;
        req_wdata <= dbg_wdata;
      end
    end
  end

  // Debug response: read data is kept until the next completed read, and ack
  // pulses for the one cycle that follows DONE
  always_ff @(posedge clk) begin
    if (Rst) begin
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= (state == DONE);
      if (dbg_access && !req_we) begin
        dbg_rdata <= (req_addr == '0) ? '0 : regs[req_addr];
      end
    end
  end

  // Register array: one write per edge, either a pipeline commit or a debug write
  always_ff @(posedge clk) begin
    if (Rst) begin
      // NOTE: the architectural state must read as zero after reset, so the
      // whole array is cleared here. That makes it flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[wb_rd] <= wb_data;
    end else if (dbg_access && req_we && (req_addr != '0)) begin
      regs[req_addr] <= req_wdata;
    end
  end

  // Retired pipeline write counter, wraps modulo 2^32
  always_ff @(posedge clk) begin
    if (Rst)         cnt_q <= '0;
    else if (commit) cnt_q <= cnt_q + 32'd1;
  end

endmodule

// File: tb/tb_register_file_wb.sv
// tb_register_file_wb: the stimulus process applies inputs once per cycle and
// queues the outputs that the reference model predicts for that cycle. A
// monitor process compares those predictions on the falling edge. Debug
// completions are checked against a separate queue of pending acks.
module tb_register_file_wb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            dbg;
  logic            mem_hold;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            dbg_req;
  logic            dbg_we;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic [XLEN-1:0] dbg_rdata;
  logic            dbg_ack;
  logic [31:0]     wb_count;

  always #5 clk = ~clk;

  register_file_wb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .Rst(rst), .dbg(dbg), .mem_hold(mem_hold),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .wb_count(wb_count)
  );

  typedef struct {
    bit          chk;
    logic [31:0] rs1e;
    logic [31:0] rs2e;
    logic [31:0] cnte;
  } rec_t;

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
  } ack_t;

  rec_t        exp_q[$];
  ack_t        ack_q[$];
  logic [31:0] m_regs [NREGS];
  logic [31:0] m_count;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference read: x0 is zero, a write retiring this cycle is visible, otherwise the array value
  function automatic logic [31:0] ref_read(input logic [AW-1:0] a, input bit c);
    if (a == '0) return 32'd0;
    if (c && (a == wb_rd)) return wb_data;
    return m_regs[a];
  endfunction

  // One clock cycle: predict the outputs for the current inputs, then advance the model over the edge
  task automatic step();
    rec_t r;
    bit   c;
    c      = !rst && wb_we && !dbg && !mem_hold && (wb_rd != '0);
    r.chk  = !rst;
    r.rs1e = ref_read(rs1, c);
    r.rs2e = ref_read(rs2, c);
    r.cnte = m_count;
    exp_q.push_back(r);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = 32'd0;
      m_count = 32'd0;
    end else if (c) begin
      m_regs[wb_rd] = wb_data;
      m_count       = m_count + 32'd1;
    end
    #1;
  endtask

  function automatic logic [AW-1:0] pick(input logic [AW-1:0] avoid);
    logic [AW-1:0] v;
    v = AW'($urandom_range(0, NREGS - 1));
    if ((avoid != '0) && (v == avoid)) v = v + 1'b1;
    return v;
  endfunction

  task automatic rand_pipe(input logic [AW-1:0] avoid);
    wb_we    = 1'($urandom_range(0, 1));
    wb_rd    = AW'($urandom_range(0, NREGS - 1));
    wb_data  = $urandom;
    mem_hold = ($urandom_range(0, 3) == 0);
    rs1      = pick(avoid);
    rs2      = pick(avoid);
    if (($urandom_range(0, 2) == 0) && ((avoid == '0) || (wb_rd != avoid))) rs1 = wb_rd;
  endtask

  // One debug access with dbg held high. The model applies the access when the
  // request is issued. Reads never target the same address during the transfer.
  task automatic dbg_xfer(input bit we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input int hold);
    ack_t a;
    int   k;
    a.is_read = !we;
    a.rdata   = (addr == '0) ? 32'd0 : m_regs[addr];
    if (we && (addr != '0)) m_regs[addr] = wdata;
    ack_q.push_back(a);
    dbg       = 1'b1;
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wdata;
    rand_pipe(addr);
    step();
    k = 0;
    while ((k < 8) && (dbg_ack !== 1'b1)) begin
      rand_pipe(addr);
      step();
      k++;
    end
    check("dbg_ack_latency", 32'(k), 32'd2);
    repeat (hold) begin
      rand_pipe(addr);
      step();
    end
    dbg_req = 1'b0;
    rand_pipe(addr);
    step();
  endtask

  // Monitor: compare the predicted outputs for each cycle, and match debug acks to pending accesses
  initial begin
    rec_t r;
    ack_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        if (r.chk) begin
          check("rs1_data", rs1_data, r.rs1e);
          check("rs2_data", rs2_data, r.rs2e);
          check("wb_count", wb_count, r.cnte);
        end
      end
      if (mon_en) begin
        if (ack_q.size() == 0) begin
          check("spurious_dbg_ack", 32'(dbg_ack), 32'd0);
        end else if (dbg_ack === 1'b1) begin
          a = ack_q.pop_front();
          if (a.is_read) check("dbg_rdata", dbg_rdata, a.rdata);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREGS; i++) m_regs[i] = 32'd0;
    m_count   = 32'd0;
    rst       = 1'b1;
    dbg       = 1'b0;
    mem_hold  = 1'b0;
    wb_we     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    rs1       = 5'd5;
    rs2       = 5'd0;
    dbg_req   = 1'b0;
    dbg_we    = 1'b0;
    dbg_addr  = '0;
    dbg_wdata = '0;
    @(posedge clk);
    #1;
    step();
    rst    = 1'b0;
    mon_en = 1;
    check("reset_dbg_ack", 32'(dbg_ack), 32'd0);
    check("reset_dbg_rdata", dbg_rdata, 32'd0);
    step();

    // Commit and same-cycle bypass
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF; rs1 = 5'd7; rs2 = 5'd0;
    step();
    wb_we = 1'b0;
    step();

    // Writes to x0 are dropped and do not count
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234; rs1 = 5'd0; rs2 = 5'd7;
    step();
    wb_we = 1'b0;
    step();

    // A held memory stall blocks writes, counting and bypass
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h55AA_55AA; mem_hold = 1'b1; rs1 = 5'd3; rs2 = 5'd3;
    repeat (5) step();
    mem_hold = 1'b0; wb_we = 1'b0;
    step();

    // Give x4 a known value for the abort test
    wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h4444_4444; rs1 = 5'd4; rs2 = 5'd7;
    step();
    wb_we = 1'b0;
    step();

    // Pipeline writes to x9 while frozen are ignored
    dbg = 1'b1; wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h9999_9999; rs1 = 5'd9; rs2 = 5'd9;
    repeat (3) step();

    // Debug write, read-back, x0 accesses and a request held high for 10 cycles
    dbg_xfer(1'b1, 5'd9, 32'hCAFE_F00D, 0);
    dbg_xfer(1'b0, 5'd9, 32'h0, 0);
    dbg_xfer(1'b1, 5'd0, 32'hFFFF_FFFF, 0);
    dbg_xfer(1'b0, 5'd0, 32'h0, 0);
    dbg_xfer(1'b0, 5'd7, 32'h0, 10);

    // dbg is dropped while in XFER: no access and no ack
    dbg = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'hFFFF_0000;
    wb_we = 1'b0; mem_hold = 1'b0; rs1 = 5'd4; rs2 = 5'd0;
    step();
    dbg = 1'b0; dbg_req = 1'b0;
    repeat (4) step();

    // Random debug accesses with random pipeline traffic that is suppressed
    for (int t = 0; t < 20; t++) begin
      dbg_xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, NREGS - 1)), $urandom,
               int'($urandom_range(0, 2)));
    end

    // Random pipeline traffic with occasional freeze cycles
    dbg_req = 1'b0;
    for (int t = 0; t < 400; t++) begin
      rand_pipe('0);
      dbg = ($urandom_range(0, 7) == 0);
      step();
    end
    dbg = 1'b0; mem_hold = 1'b0;

    // Counter wrap: preload all-ones, then one commit to x1
    wb_we = 1'b0;
    step();
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_count = 32'hFFFF_FFFF;
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h1111_1111; rs1 = 5'd1; rs2 = 5'd2;
    step();
    wb_we = 1'b0;
    step();

    // Reset in the middle of a debug access, together with a pipeline write
    dbg = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'h5555_5555;
    step();
    rst = 1'b1; dbg = 1'b0; dbg_req = 1'b0; wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'h6666_6666;
    step();
    rst = 1'b0; wb_we = 1'b0; rs1 = 5'd5; rs2 = 5'd6;
    repeat (4) step();

    @(negedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
